// File: rtl/e203_subsys_irq_cond_if.sv
// ICB register-slave bundle between a bus master and the interrupt conditioner.
interface e203_subsys_irq_cond_if #(
  parameter int AW = 32
);
  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic [AW-1:0] icb_cmd_addr;
  logic          icb_cmd_read;
  logic [31:0]   icb_cmd_wdata;
  logic [3:0]    icb_cmd_wmask;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic          icb_rsp_err;
  logic [31:0]   icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );
endinterface

// File: rtl/e203_subsys_irq_cond.sv
// Interrupt conditioner ahead of the PLIC: synchronize, deglitch, optional sticky
// edge capture, registered PLIC requests, and an ICB slave for MODE/PEND/LEVEL.
module e203_subsys_irq_cond #(
  parameter int NIRQ     = 16,
  parameter int SYNC_DP  = 2,
  parameter int FILT_CYC = 4,
  parameter int AW       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NIRQ-1:0]        irq_a,
  output logic [NIRQ-1:0]        plic_irq_o,
  e203_subsys_irq_cond_if.slave  icb
);

  logic [NIRQ-1:0] sync_q [SYNC_DP];
  logic [NIRQ-1:0] sync_d [SYNC_DP];
  logic [NIRQ-1:0] sync_lvl;
  logic [NIRQ-1:0] filt;
  logic [NIRQ-1:0] filt_dly_q, filt_dly_d;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] mode_q, mode_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] plic_q, plic_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    sync_d[0] = irq_a;
    for (int k = 1; k < SYNC_DP; k++) sync_d[k] = sync_q[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_DP; k++) sync_q[k] <= '0;
    end else begin
      for (int k = 0; k < SYNC_DP; k++) sync_q[k] <= sync_d[k];
    end
  end

  assign sync_lvl = sync_q[SYNC_DP-1];

  // The filtered level only follows the synchronized input after FILT_CYC
  // consecutive disagreeing cycles; any agreeing cycle restarts the count.
  if (FILT_CYC == 0) begin : g_filt_bypass
    assign filt = sync_lvl;
  end else begin : g_filt
    localparam int CW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(FILT_CYC - 1);

    logic [CW-1:0]   cnt_q [NIRQ];
    logic [CW-1:0]   cnt_d [NIRQ];
    logic [NIRQ-1:0] lvl_q, lvl_d;

    always_comb begin
      lvl_d = lvl_q;
      for (int i = 0; i < NIRQ; i++) begin
        cnt_d[i] = '0;
        if (sync_lvl[i] != lvl_q[i]) begin
          if (cnt_q[i] == CNT_TC) lvl_d[i] = sync_lvl[i];
          else                    cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lvl_q <= '0;
        for (int i = 0; i < NIRQ; i++) cnt_q[i] <= '0;
      end else begin
        lvl_q <= lvl_d;
        for (int i = 0; i < NIRQ; i++) cnt_q[i] <= cnt_d[i];
      end
    end

    assign filt = lvl_q;
  end

  assign filt_dly_d = filt;
  assign rise       = filt & ~filt_dly_q;

  logic [AW-1:0]   cmd_addr;
  logic [1:0]      cmd_off;
  logic            cmd_ready;
  logic            cmd_acc;
  logic            cmd_wr;
  logic [31:0]     byte_en;
  logic [NIRQ-1:0] wbits;
  logic [NIRQ-1:0] wmask_n;
  logic [NIRQ-1:0] w1c;
  logic [31:0]     rd_val;
  logic            unused_ok;

  assign cmd_addr  = icb.icb_cmd_addr;
  assign cmd_off   = cmd_addr[3:2];
  assign cmd_ready = ~rsp_valid_q | icb.icb_rsp_ready;
  assign cmd_acc   = icb.icb_cmd_valid & cmd_ready;
  assign cmd_wr    = cmd_acc & ~icb.icb_cmd_read;
  assign byte_en   = {{8{icb.icb_cmd_wmask[3]}}, {8{icb.icb_cmd_wmask[2]}},
                      {8{icb.icb_cmd_wmask[1]}}, {8{icb.icb_cmd_wmask[0]}}};
  assign wmask_n   = byte_en[NIRQ-1:0];
  assign wbits     = icb.icb_cmd_wdata[NIRQ-1:0] & wmask_n;
  assign unused_ok = ^{cmd_addr, icb.icb_cmd_wdata, byte_en};

  always_comb begin
    mode_d = mode_q;
    w1c    = '0;
    if (cmd_wr && cmd_off == 2'd0) mode_d = (mode_q & ~wmask_n) | wbits;
    if (cmd_wr && cmd_off == 2'd1) w1c = wbits;
    // Set beats W1C; leaving edge mode drops the pending bit.
    pend_d = ((pend_q & ~w1c) | (rise & mode_q)) & mode_d;
    plic_d = (mode_q & pend_q) | (~mode_q & filt);
  end

  always_comb begin
    rd_val = '0;
    case (cmd_off)
      2'd0:    rd_val = 32'(mode_q);
      2'd1:    rd_val = 32'(pend_q);
      2'd2:    rd_val = 32'(filt);
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (cmd_acc) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = (cmd_off == 2'd3);
      rsp_rdata_d = icb.icb_cmd_read ? rd_val : 32'h0;
    end else if (icb.icb_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_dly_q  <= '0;
      mode_q      <= '0;
      pend_q      <= '0;
      plic_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      filt_dly_q  <= filt_dly_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      plic_q      <= plic_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign plic_irq_o        = plic_q;
  assign icb.icb_cmd_ready = cmd_ready;
  assign icb.icb_rsp_valid = rsp_valid_q;
  assign icb.icb_rsp_err   = rsp_err_q;
  assign icb.icb_rsp_rdata = rsp_rdata_q;

endmodule
